// File: rtl/servo_pkg.sv
// Shared servo timing constants, capture FSM encoding and the width-to-control mapping.
// Imported by the capture block and by the servo generator so both use one offset.
package servo_pkg;

    localparam int PWM_FRAME_CLKS    = 1000000;
    localparam int SERVO_CTRL_OFFSET = 27000;
    localparam int SERVO_CTRL_MAX    = 100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } capture_state_t;

    // Inverse of the generator encoding (pulse = offset + control), floored at zero.
    function automatic logic [31:0] width_to_control(input logic [19:0] w,
                                                     input logic [31:0] offset);
        logic [31:0] w_ext;
        w_ext = {12'd0, w};
        return (w_ext < offset) ? 32'd0 : (w_ext - offset);
    endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// Brings the raw PWM pin into the clk domain and emits one-cycle rise/fall pulses.
// SERVO_CAPTURE_GLITCH_FILTER_EN inserts a FILTER_LEN-cycle stability filter before edge detect.
module pwm_input_conditioner
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
#(
    parameter int FILTER_LEN = 16
)
`endif
(
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    // NOTE: every flop here uses <= so all stages sample the same pre-edge values;
    // a blocking = would collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             filt_level;

    // Level moves only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
            filt_level <= 1'b0;
        end else if (sync_q2 == filt_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
            stable_cnt <= '0;
            filt_level <= sync_q2;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = filt_level;
`else
    assign level = sync_q2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
        end
    end

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high time and rise-to-rise period, publishes a control value.
// Optional glitch filter enabled with SERVO_CAPTURE_GLITCH_FILTER_EN.
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int MIN_WIDTH    = SERVO_CTRL_OFFSET,
    parameter int MAX_WIDTH    = SERVO_CTRL_OFFSET + SERVO_CTRL_MAX,
    parameter int TIMEOUT_CLKS = 1048575
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
  , parameter int FILTER_LEN   = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pwm_in,
    output logic [19:0] width,
    output logic [19:0] period,
    output logic [31:0] control,
    output logic        in_range,
    output logic        valid,
    output logic        signal_lost
);

    localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT_CLKS);
    localparam logic [31:0] MIN_W       = 32'(MIN_WIDTH);
    localparam logic [31:0] MAX_W       = 32'(MAX_WIDTH);

    capture_state_t state;
    logic [19:0]    hi_cnt;
    logic [19:0]    per_cnt;
    logic           rise;
    logic           fall;
    logic           at_timeout;
    logic [19:0]    per_next;
    logic [31:0]    hi_ext;

    pwm_input_conditioner
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .pwm_in  (pwm_in),
        .rise    (rise),
        .fall    (fall)
    );

    // A fall landing on the timeout count still wins; holding per_cnt keeps it from wrapping.
    assign at_timeout = (per_cnt == TIMEOUT_CNT);
    assign per_next   = at_timeout ? per_cnt : per_cnt + 20'd1;
    assign hi_ext     = {12'd0, hi_cnt};

    // NOTE: only control state and published registers are reset here; no memories exist,
    // and asynchronous reset discards any partial measurement immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            width       <= '0;
            period      <= '0;
            control     <= '0;
            in_range    <= 1'b0;
            valid       <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= HIGH;
                        hi_cnt  <= 20'd1;
                        per_cnt <= 20'd1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        per_cnt <= per_next;
                    end else if (at_timeout) begin
                        state       <= IDLE;
                        signal_lost <= 1'b1;
                    end else begin
                        hi_cnt  <= hi_cnt + 20'd1;
                        per_cnt <= per_cnt + 20'd1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        width       <= hi_cnt;
                        period      <= per_cnt;
                        control     <= width_to_control(hi_cnt, MIN_W);
                        in_range    <= (hi_ext >= MIN_W) && (hi_ext <= MAX_W);
                        valid       <= 1'b1;
                        signal_lost <= 1'b0;
                        state       <= HIGH;
                        hi_cnt      <= 20'd1;
                        per_cnt     <= 20'd1;
                    end else if (at_timeout) begin
                        state       <= IDLE;
                        signal_lost <= 1'b1;
                    end else begin
                        per_cnt <= per_cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed bench for servo_pwm_capture with scaled-down widths and timeout.
// Honours SERVO_CAPTURE_GLITCH_FILTER_EN for the glitch and latency expectations.
`timescale 1ns/1ps
module tb_servo_pwm_capture;

    localparam int MIN_W = 100;
    localparam int MAX_W = 400;
    localparam int TO    = 3000;
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT_EXTRA = 16;
`else
    localparam int LAT_EXTRA = 0;
`endif
    // Pin edge to signal_lost at the next negedge: 3 conditioning edges, 1 FSM edge, TO counts.
    localparam int LOST_LAT = TO + 4 + LAT_EXTRA;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pwm_in;
    logic [19:0] width;
    logic [19:0] period;
    logic [31:0] control;
    logic        in_range;
    logic        valid;
    logic        signal_lost;

    servo_pwm_capture #(
        .MIN_WIDTH    (MIN_W),
        .MAX_WIDTH    (MAX_W),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pwm_in      (pwm_in),
        .width       (width),
        .period      (period),
        .control     (control),
        .in_range    (in_range),
        .valid       (valid),
        .signal_lost (signal_lost)
    );

    always #10 clk = ~clk;

    typedef struct {
        int high;
        int per;
        int exp_width;
        int exp_period;
        int exp_control;
        int exp_in_range;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int dbl_valid = 0;
    logic        prev_valid = 1'b0;
    logic [19:0] cap_width;
    logic [19:0] cap_period;
    logic [31:0] cap_control;
    logic        cap_in_range;
    logic        cap_lost;

    always @(posedge clk) cyc <= cyc + 1;

    // Latch whatever is published on each valid strobe.
    always @(negedge clk) begin
        prev_valid <= valid;
        if (valid === 1'b1) begin
            valid_cnt    <= valid_cnt + 1;
            cap_width    <= width;
            cap_period   <= period;
            cap_control  <= control;
            cap_in_range <= in_range;
            cap_lost     <= signal_lost;
            if (prev_valid === 1'b1) dbl_valid <= dbl_valid + 1;
        end
    end

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic run_frame(input int h, input int p);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic wait_lost(input int limit, output int seen_at);
        seen_at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (signal_lost === 1'b1) begin
                seen_at = cyc;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_width"},    width,       0);
        check({tag, "_period"},   period,      0);
        check({tag, "_control"},  control,     0);
        check({tag, "_in_range"}, in_range,    0);
        check({tag, "_valid"},    valid,       0);
        check({tag, "_lost"},     signal_lost, 1);
    endtask

    task automatic check_capture(input string tag, input int w, input int p,
                                 input int c, input int r);
        check({tag, "_width"},    cap_width,    w);
        check({tag, "_period"},   cap_period,   p);
        check({tag, "_control"},  cap_control,  c);
        check({tag, "_in_range"}, cap_in_range, r);
        check({tag, "_lost_at_valid"}, cap_lost, 0);
    endtask

    initial begin
        int n0;
        int n0cyc;
        int seen;

        //          high  per   width period control in_range
        vec[0] = '{ 200, 1000,  200, 1000,  100, 1 };
        vec[1] = '{ 200, 1000,  200, 1000,  100, 1 };
        vec[2] = '{ 200, 1000,  200, 1000,  100, 1 };
        vec[3] = '{  20, 1000,   20, 1000,    0, 0 };
        vec[4] = '{ 450,  700,  450,  700,  350, 0 };
        vec[5] = '{ 100,  900,  100,  900,    0, 1 };
        vec[6] = '{  99, 1000,   99, 1000,    0, 0 };
        vec[7] = '{ 400, 1000,  400, 1000,  300, 1 };
        vec[8] = '{ 401,  800,  401,  800,  301, 0 };
        vec[9] = '{ 200, 1000,  200, 1000,  100, 1 };

        reset_n = 1'b0;
        pwm_in  = 1'b0;
        #25;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Each frame's rise publishes the previous table entry.
        for (int i = 0; i < NV; i++) begin
            n0 = valid_cnt;
            run_frame(vec[i].high, vec[i].per);
            if (i == 0) begin
                check("first_frame_unpublished", valid_cnt - n0, 0);
                check("lost_before_first_valid", signal_lost, 1);
            end else begin
                check($sformatf("vec%0d_valid_count", i - 1), valid_cnt - n0, 1);
                check_capture($sformatf("vec%0d", i - 1), vec[i-1].exp_width,
                              vec[i-1].exp_period, vec[i-1].exp_control,
                              vec[i-1].exp_in_range);
            end
        end

        // 5-cycle glitch inside the low phase of a 200/1000 frame.
        n0 = valid_cnt;
        pwm_in = 1'b1; repeat (200) @(negedge clk);
        pwm_in = 1'b0; repeat (400) @(negedge clk);
        pwm_in = 1'b1; repeat (5)   @(negedge clk);
        pwm_in = 1'b0; repeat (395) @(negedge clk);
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
        check("glitch_valid_count", valid_cnt - n0, 1);
        n0 = valid_cnt;
        run_frame(200, 1000);
        check("glitch_next_valid_count", valid_cnt - n0, 1);
        check_capture("glitch_filtered", 200, 1000, 100, 1);
`else
        check("glitch_valid_count", valid_cnt - n0, 2);
        check_capture("glitch_first", 200, 600, 100, 1);
        n0 = valid_cnt;
        run_frame(200, 1000);
        check("glitch_next_valid_count", valid_cnt - n0, 1);
        check_capture("glitch_second", 5, 400, 0, 0);
`endif

        // Pin held low after a published frame.
        n0 = valid_cnt;
        n0cyc = cyc;
        pwm_in = 1'b1; repeat (200) @(negedge clk);
        pwm_in = 1'b0;
        check("timeout_frame_published", valid_cnt - n0, 1);
        check("lost_clear_before_timeout", signal_lost, 0);
        wait_lost(TO + 200, seen);
        check("timeout_low_latency", seen - n0cyc, LOST_LAT);
        check("timeout_hold_width",  width,   200);
        check("timeout_hold_period", period,  1000);
        check("timeout_hold_control", control, 100);
        check("timeout_no_valid", valid_cnt - n0, 1);

        // Frames resume: one unpublished frame, then a valid.
        n0 = valid_cnt;
        run_frame(200, 1000);
        check("resume_first_unpublished", valid_cnt - n0, 0);
        check("resume_lost_still_set", signal_lost, 1);
        run_frame(200, 1000);
        check("resume_valid_count", valid_cnt - n0, 1);
        check_capture("resume", 200, 1000, 100, 1);

        // Asynchronous reset in the middle of a high phase.
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_values("mid_high_reset");
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n0 = valid_cnt;
        run_frame(150, 900);
        check("recover_first_unpublished", valid_cnt - n0, 0);
        run_frame(150, 900);
        check("recover_valid_count", valid_cnt - n0, 1);
        check_capture("recover", 150, 900, 50, 1);

        // Pin stuck high: the rise publishes the prior frame, then only the timeout.
        n0 = valid_cnt;
        n0cyc = cyc;
        pwm_in = 1'b1;
        wait_lost(TO + 200, seen);
        check("stuck_high_latency", seen - n0cyc, LOST_LAT);
        repeat (200) @(negedge clk);
        pwm_in = 1'b0; repeat (300) @(negedge clk);
        pwm_in = 1'b1; repeat (50)  @(negedge clk);
        check("stuck_high_valid_count", valid_cnt - n0, 1);
        check("stuck_high_lost", signal_lost, 1);
        check("valid_single_cycle", dbl_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
